// File: rtl/renkon_serial_drain_pkg.sv
// Shared constants and types for the serial-matrix drain block.
// Provides default widths, read latency, output buffer depth and FSM state encoding.
package renkon_serial_drain_pkg;

   localparam int unsigned RENKON_DWIDTH  = 16;
   localparam int unsigned RENKON_OUTSIZE = 10;
   localparam int unsigned RENKON_CORELOG = 3;
   localparam int unsigned RENKON_CORE    = 1 << RENKON_CORELOG;
   localparam int unsigned RENKON_RD_LAT  = 2;
   localparam int unsigned RENKON_DEPTH   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } drain_state_t;

endpackage

// File: rtl/renkon_drain_fifo.sv
// Small output buffer for the drain block, built as a shift register so the
// head word is always a flop (m_data holds cleanly while stalled).
// Ports: clk, xrst (async active-low), wr_en/wr_data push, rd_en pop,
// rd_data head word, not_empty flag, count of stored words.
module renkon_drain_fifo #(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           xrst,
   input  logic                           wr_en,
   input  logic [DWIDTH-1:0]              wr_data,
   input  logic                           rd_en,
   output logic [DWIDTH-1:0]              rd_data,
   output logic                           not_empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DWIDTH-1:0] ent_q [DEPTH];
   logic [DWIDTH-1:0] ent_d [DEPTH];
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic [CW-1:0]     widx_c;
   logic              rd_c;
   logic              ne_q;

   // Pop only a non-empty buffer; a simultaneous push lands one slot lower.
   always_comb begin
      ent_d   = ent_q;
      rd_c    = rd_en && (count_q != '0);
      widx_c  = rd_c ? (count_q - CW'(1)) : count_q;
      count_d = count_q + CW'(wr_en) - CW'(rd_c);
      if (rd_c) begin
         for (int unsigned i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      end
      if (wr_en) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) == widx_c) ent_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         count_q <= '0;
         ne_q    <= 1'b0;
      end else begin
         ent_q   <= ent_d;
         count_q <= count_d;
         ne_q    <= (count_d != '0);
      end
   end

   assign rd_data   = ent_q[0];
   assign not_empty = ne_q;
   assign count     = count_q;

endmodule

// File: rtl/renkon_serial_drain.sv
// Drains core_num banks x out_len words from the serial matrix in bank-major
// order into a valid/ready stream, throttling reads so the buffer never overflows.
// Ports: clk, xrst (async active-low); req/out_len/core_num start a drain;
// serial_re/serial_addr read the matrix, in_data returns RD_LAT after issue;
// m_valid/m_ready/m_data output stream; busy while draining, ack done pulse.
module renkon_serial_drain
   import renkon_serial_drain_pkg::*;
#(
   parameter int unsigned DWIDTH  = RENKON_DWIDTH,
   parameter int unsigned OUTSIZE = RENKON_OUTSIZE,
   parameter int unsigned CORELOG = RENKON_CORELOG,
   parameter int unsigned RD_LAT  = RENKON_RD_LAT,
   parameter int unsigned DEPTH   = RENKON_DEPTH
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     req,
   input  logic [OUTSIZE-1:0]       out_len,
   input  logic [CORELOG:0]         core_num,
   output logic [CORELOG:0]         serial_re,
   output logic [OUTSIZE-1:0]       serial_addr,
   input  logic signed [DWIDTH-1:0] in_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [DWIDTH-1:0] m_data,
   output logic                     busy,
   output logic                     ack
);

   localparam int unsigned BW = CORELOG + 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam int unsigned PW = $clog2(RD_LAT + 1);

   drain_state_t        state_q, state_d;
   logic [OUTSIZE-1:0]  len_q, addr_q, addr_d, cur_len;
   logic [BW-1:0]       num_q, bank_q, bank_d, cur_num;
   logic [RD_LAT-1:0]   vpipe_q;
   logic [CW-1:0]       fifo_count;
   logic [PW-1:0]       inflight_c;
   logic                start_c, nz_c, room_c, issue_c, last_c;
   logic [BW-1:0]       re_q;
   logic [OUTSIZE-1:0]  raddr_q;
   logic                busy_q, ack_q;
   logic [DWIDTH-1:0]   head_data;

   // Reads still travelling through the matrix pipeline.
   always_comb begin
      inflight_c = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) inflight_c = inflight_c + PW'(vpipe_q[i]);
   end

   // The first read issues straight from IDLE using the live inputs so the
   // first word reaches the output RD_LAT+1 cycles after the request.
   assign start_c = (state_q == ST_IDLE) && req;
   assign nz_c    = (out_len != '0) && (core_num != '0);
   assign cur_len = (state_q == ST_IDLE) ? out_len : len_q;
   assign cur_num = (state_q == ST_IDLE) ? core_num : num_q;
   assign room_c  = (SW'(fifo_count) + SW'(inflight_c)) < SW'(DEPTH);
   assign issue_c = room_c && ((state_q == ST_ISSUE) || (start_c && nz_c));
   assign last_c  = (addr_q == cur_len - OUTSIZE'(1)) && (bank_q == cur_num - BW'(1));

   // Next-state and read-address counters.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      bank_d  = bank_q;
      if (issue_c) begin
         if (addr_q == cur_len - OUTSIZE'(1)) begin
            addr_d = '0;
            bank_d = bank_q + BW'(1);
         end else begin
            addr_d = addr_q + OUTSIZE'(1);
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (!nz_c)                  state_d = ST_DONE;
               else if (issue_c && last_c) state_d = ST_FLUSH;
               else                        state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (issue_c && last_c) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if ((fifo_count == '0) && (vpipe_q == '0)) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            addr_d  = '0;
            bank_d  = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         num_q   <= '0;
         addr_q  <= '0;
         bank_q  <= '0;
         vpipe_q <= '0;
         re_q    <= '0;
         raddr_q <= '0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_c) begin
            len_q <= out_len;
            num_q <= core_num;
         end
         addr_q  <= addr_d;
         bank_q  <= bank_d;
         vpipe_q <= (vpipe_q << 1) | RD_LAT'(issue_c);
         re_q    <= issue_c ? (bank_q + BW'(1)) : '0;
         raddr_q <= issue_c ? addr_q : '0;
         busy_q  <= (state_d != ST_IDLE);
         ack_q   <= (state_q == ST_DONE);
      end
   end

   renkon_drain_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .xrst      (xrst),
      .wr_en     (vpipe_q[RD_LAT-1]),
      .wr_data   (in_data),
      .rd_en     (m_valid && m_ready),
      .rd_data   (head_data),
      .not_empty (m_valid),
      .count     (fifo_count)
   );

   assign m_data      = head_data;
   assign serial_re   = re_q;
   assign serial_addr = raddr_q;
   assign busy        = busy_q;
   assign ack         = ack_q;

endmodule

// File: tb/tb_renkon_serial_drain.sv
// Scoreboard bench for renkon_serial_drain: requests push expected words,
// a negedge monitor pops and compares each transferred word.
module tb_renkon_serial_drain;

   localparam int unsigned DW = 16;
   localparam int unsigned OS = 10;
   localparam int unsigned CL = 3;

   logic                 clk = 1'b0;
   logic                 xrst;
   logic                 req;
   logic [OS-1:0]        out_len;
   logic [CL:0]          core_num;
   logic [CL:0]          serial_re;
   logic [OS-1:0]        serial_addr;
   logic signed [DW-1:0] in_data;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] m_data;
   logic                 busy;
   logic                 ack;

   always #5 clk = ~clk;

   renkon_serial_drain #(
      .DWIDTH(DW), .OUTSIZE(OS), .CORELOG(CL), .RD_LAT(2), .DEPTH(4)
   ) dut (
      .clk(clk), .xrst(xrst), .req(req), .out_len(out_len), .core_num(core_num),
      .serial_re(serial_re), .serial_addr(serial_addr), .in_data(in_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .ack(ack)
   );

   // Serial matrix model: synchronous read, bank b address a holds b*256+a.
   logic signed [DW-1:0] rdat;
   always @(posedge clk) begin
      if (serial_re != '0) rdat <= DW'((int'(serial_re) - 1) * 256 + int'(serial_addr));
      else                 rdat <= 16'sh7bad;
   end
   assign in_data = rdat;

   int checks = 0;
   int errors = 0;
   int words_out = 0;
   int acks = 0;
   int exp_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare transfers against the scoreboard and check stall hold.
   logic                 stall_prev = 1'b0;
   logic signed [DW-1:0] held = '0;
   always @(negedge clk) begin
      if (xrst) begin
         if (stall_prev) begin
            chk("hold_valid", longint'(m_valid), 1);
            chk("hold_data", longint'(m_data), longint'(held));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", longint'(m_data), -1);
            end else begin
               chk("word", longint'(m_data), longint'(exp_q.pop_front()));
               words_out++;
            end
         end
         stall_prev = m_valid && !m_ready;
         held       = m_data;
         if (ack) begin
            acks++;
            chk("ack_drained", longint'(exp_q.size()), 0);
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_words(input int len, input int num);
      for (int b = 0; b < num; b++)
         for (int a = 0; a < len; a++) exp_q.push_back(b * 256 + a);
   endtask

   // Drives req for the current cycle; returns one cycle later with req low.
   task automatic pulse_req(input int len, input int num);
      out_len  = OS'(len);
      core_num = (CL+1)'(num);
      req      = 1'b1;
      step(1);
      req      = 1'b0;
   endtask

   task automatic wait_ack(input int a0, input string name);
      for (int k = 0; k < 600 && acks == a0; k++) step(1);
      chk(name, longint'(acks - a0), 1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_re"},    longint'(serial_re), 0);
      chk({tag, "_addr"},  longint'(serial_addr), 0);
      chk({tag, "_valid"}, longint'(m_valid), 0);
      chk({tag, "_data"},  longint'(m_data), 0);
      chk({tag, "_busy"},  longint'(busy), 0);
      chk({tag, "_ack"},   longint'(ack), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a0, w0, k, run, n_iss, last_addr;
      xrst = 1'b0; req = 1'b0; out_len = '0; core_num = '0; m_ready = 1'b0;

      // Reset values
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk); #1;
      xrst = 1'b1;
      step(2);

      // Basic drain 3x2, latency and back-to-back words
      m_ready = 1'b1;
      push_words(3, 2);
      a0 = acks; w0 = words_out;
      pulse_req(3, 2);
      chk("busy_after_req", longint'(busy), 1);
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (m_valid) break;
      end
      chk("first_valid_latency", longint'(k), 3);
      run = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (m_valid) run++;
      end
      chk("burst_valid", longint'(run), 6);
      @(posedge clk); #1;
      wait_ack(a0, "ack_basic");
      chk("basic_count", longint'(words_out - w0), 6);
      step(1);
      chk("busy_after_ack", longint'(busy), 0);

      // Zero-length requests complete without data
      for (int v = 0; v < 2; v++) begin
         a0 = acks; w0 = words_out;
         if (v == 0) pulse_req(0, 2);
         else        pulse_req(3, 0);
         @(negedge clk);
         chk("zero_busy_c1", longint'(busy), 1);
         chk("zero_ack_c1", longint'(ack), 0);
         @(negedge clk);
         chk("zero_busy_c2", longint'(busy), 0);
         chk("zero_ack_c2", longint'(ack), 1);
         @(negedge clk);
         chk("zero_ack_c3", longint'(ack), 0);
         @(posedge clk); #1;
         chk("zero_acks", longint'(acks - a0), 1);
         chk("zero_words", longint'(words_out - w0), 0);
      end

      // Back-pressure: only DEPTH reads issue while the output is stalled
      m_ready = 1'b0;
      push_words(8, 8);
      a0 = acks; w0 = words_out;
      pulse_req(8, 8);
      n_iss = 0; last_addr = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (serial_re != '0) begin
            n_iss++;
            last_addr = int'(serial_addr);
         end
      end
      chk("stall_issues", longint'(n_iss), 4);
      chk("stall_last_addr", longint'(last_addr), 3);
      chk("stall_re_idle", longint'(serial_re), 0);
      chk("stall_valid", longint'(m_valid), 1);
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_ack(a0, "ack_stall");
      chk("stall_count", longint'(words_out - w0), 64);

      // Random back-pressure
      push_words(5, 8);
      a0 = acks; w0 = words_out;
      pulse_req(5, 8);
      for (int i = 0; i < 2000 && acks == a0; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         step(1);
      end
      m_ready = 1'b1;
      chk("ack_random", longint'(acks - a0), 1);
      chk("random_count", longint'(words_out - w0), 40);

      // Reset in the middle of a drain
      push_words(8, 8);
      w0 = words_out;
      pulse_req(8, 8);
      for (int i = 0; i < 300 && words_out < w0 + 10; i++) step(1);
      chk("pre_reset_words", longint'(words_out - w0), 10);
      #2;
      xrst = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      exp_q.delete();
      a0 = acks;
      step(3);
      xrst = 1'b1;
      step(10);
      chk("no_ack_after_reset", longint'(acks - a0), 0);
      push_words(2, 1);
      w0 = words_out;
      pulse_req(2, 1);
      @(negedge clk);
      chk("restart_re", longint'(serial_re), 1);
      chk("restart_addr", longint'(serial_addr), 0);
      @(posedge clk); #1;
      wait_ack(a0, "ack_restart");
      chk("restart_count", longint'(words_out - w0), 2);

      // req during busy is ignored
      push_words(3, 1);
      a0 = acks; w0 = words_out;
      pulse_req(3, 1);
      step(1);
      out_len = OS'(6); core_num = (CL+1)'(4); req = 1'b1;
      step(1);
      req = 1'b0;
      wait_ack(a0, "ack_ignore");
      step(12);
      chk("ignore_words", longint'(words_out - w0), 3);
      chk("ignore_acks", longint'(acks - a0), 1);
      chk("ignore_busy", longint'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
